// File: rtl/if_stage_ibuf.sv
// if_stage_ibuf: instruction-fetch stage with split request/response SRAM
// interface, a PC tag FIFO for in-flight requests and an instruction buffer.
// Redirects (exception > eret > taken branch) flush the buffer and cancel
// every in-flight response.
// Optional feature macro: IF_ADEL_EN (fetch address-error detection).
module if_stage_ibuf #(
    parameter int          IBUF_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'hbfc00000,
    parameter logic [31:0] EX_ENTRY        = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [33:0] br_bus,
    input  logic        ws_ex,
    input  logic        eret_flush,
    input  logic [31:0] cp0_epc,
    output logic        fs_to_ds_valid,
    output logic [97:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam int PW = $clog2(IBUF_DEPTH);
    localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PW:0]   DEPTH_C  = (PW+1)'(IBUF_DEPTH);
    localparam logic [PW+1:0] DEPTH_W  = (PW+2)'(IBUF_DEPTH);
    localparam logic [OW-1:0] MAX_C    = OW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TAG_LAST = TW'(MAX_OUTSTANDING - 1);

    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;

    assign br_stall  = br_bus[33];
    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wdata = 32'h0;

    // Buffer entry layout: {ex, badvaddr[31:0], inst[31:0], pc[31:0]}
    logic [96:0] ibuf_q [IBUF_DEPTH];
    logic [31:0] tag_q  [MAX_OUTSTANDING];

    logic [31:0]   fpc_q, fpc_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [OW-1:0] outstanding_q, outstanding_d;
    logic [OW-1:0] cancel_q, cancel_d;
    logic [TW-1:0] tag_wr_q, tag_wr_d;
    logic [TW-1:0] tag_rd_q, tag_rd_d;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        pop;
    logic [PW:0] count_after_pop;
    logic        credit_ok;
    logic        issue;
    logic        resp_keep;
    logic        push;
    logic [96:0] push_entry;
    logic [96:0] head_entry;
    logic        misaligned;
    logic        adel_push;

    // Redirect detection and target selection by priority
    always_comb begin
        redirect = ws_ex | eret_flush | br_taken;
        if (ws_ex)
            redirect_pc = EX_ENTRY;
        else if (eret_flush)
            redirect_pc = cp0_epc;
        else
            redirect_pc = br_target;
    end

    // Decode-side head presentation; a redirect hides the head in the same cycle
    always_comb begin
        head_entry      = ibuf_q[head_q];
        fs_to_ds_valid  = !reset && !redirect && (count_q != '0);
        fs_to_ds_bus    = fs_to_ds_valid ? {head_entry[96], 1'b0, head_entry[95:0]} : '0;
        pop             = fs_to_ds_valid && ds_allowin;
        count_after_pop = count_q - (PW+1)'(pop);
    end

`ifdef IF_ADEL_EN
    logic adel_halt_q, adel_halt_d;

    // Misaligned fetch becomes a buffered exception entry once older fetches have drained
    always_comb begin
        misaligned  = (fpc_q[1:0] != 2'b00);
        adel_push   = misaligned && !adel_halt_q && !redirect &&
                      (outstanding_q == '0) && (count_after_pop < DEPTH_C);
        adel_halt_d = adel_halt_q;
        if (redirect)
            adel_halt_d = 1'b0;
        else if (adel_push)
            adel_halt_d = 1'b1;
    end

    // Fetch stays halted after an address error until the next redirect
    always_ff @(posedge clk) begin
        if (reset)
            adel_halt_q <= 1'b0;
        else
            adel_halt_q <= adel_halt_d;
    end
`else
    // No alignment checking: every address is requested as-is
    always_comb begin
        misaligned = 1'b0;
        adel_push  = 1'b0;
    end
`endif

    // Request generation: credit covers both outstanding fetches and buffered words
    always_comb begin
        credit_ok      = ((PW+2)'(outstanding_q) + {1'b0, count_after_pop}) < DEPTH_W;
        inst_sram_req  = !reset && !redirect && !br_stall && !misaligned &&
                         (outstanding_q < MAX_C) && credit_ok;
        inst_sram_addr = fpc_q;
        issue          = inst_sram_req && inst_sram_addr_ok;
    end

    // Next-state for PC, buffer pointers, outstanding and cancel counters
    always_comb begin
        resp_keep  = inst_sram_data_ok && (cancel_q == '0) && !redirect;
        push       = resp_keep || adel_push;
        push_entry = adel_push ? {1'b1, fpc_q, 32'h0, fpc_q}
                               : {1'b0, 32'h0, inst_sram_rdata, tag_q[tag_rd_q]};

        fpc_d = fpc_q;
        if (redirect)
            fpc_d = redirect_pc;
        else if (issue)
            fpc_d = fpc_q + 32'd4;

        outstanding_d = outstanding_q;
        case ({issue, inst_sram_data_ok})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        cancel_d = cancel_q;
        if (redirect)
            cancel_d = outstanding_d;
        else if (inst_sram_data_ok && (cancel_q != '0))
            cancel_d = cancel_q - OW'(1);

        tag_wr_d = tag_wr_q;
        if (issue)
            tag_wr_d = (tag_wr_q == TAG_LAST) ? '0 : tag_wr_q + TW'(1);
        tag_rd_d = tag_rd_q;
        if (inst_sram_data_ok)
            tag_rd_d = (tag_rd_q == TAG_LAST) ? '0 : tag_rd_q + TW'(1);

        if (redirect) begin
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
            head_d  = head_q + PW'(pop);
            tail_d  = tail_q + PW'(push);
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q         <= RESET_PC;
            count_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            outstanding_q <= '0;
            cancel_q      <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
        end else begin
            fpc_q         <= fpc_d;
            count_q       <= count_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            outstanding_q <= outstanding_d;
            cancel_q      <= cancel_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
        end
    end

    // Buffer storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (push)
            ibuf_q[tail_q] <= push_entry;
    end

    // PC tag of each issued request, consumed in order by responses
    always_ff @(posedge clk) begin
        if (issue)
            tag_q[tag_wr_q] <= fpc_q;
    end

endmodule

// File: tb/tb_if_stage_ibuf.sv
// Bench for if_stage_ibuf: in-order SRAM responder plus a reference model of
// the fetch stream (expected requests, credit, cancellation, delivery queue).
module tb_if_stage_ibuf;

    localparam int          DEPTH = 4;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'hbfc00000;
    localparam logic [31:0] EXE   = 32'hbfc00380;
`ifdef IF_ADEL_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic        br_stall, br_taken;
    logic [31:0] br_target;
    logic [33:0] br_bus;
    logic        ws_ex, eret_flush;
    logic [31:0] cp0_epc;
    logic        fs_to_ds_valid;
    logic [97:0] fs_to_ds_bus;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        resp_en;

    assign br_bus = {br_stall, br_taken, br_target};

    always #5 clk = ~clk;

    if_stage_ibuf #(
        .IBUF_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC), .EX_ENTRY(EXE)
    ) dut (
        .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
        .ws_ex(ws_ex), .eret_flush(eret_flush), .cp0_epc(cp0_epc),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata)
    );

    int          total = 0;
    int          bad   = 0;
    int          n_issue = 0;
    int          n_deliv = 0;
    logic        delivered;
    logic [97:0] last_bus;

    logic [31:0] acc_q[$];     // addresses accepted by the SRAM, awaiting data_ok
    logic [32:0] infl_q[$];    // model in-flight: {live, pc}
    logic [97:0] exp_q[$];     // model buffer contents, head first
    logic [31:0] exp_fpc;
    logic        halted;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [97:0] obs, input logic [97:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle; called at a negedge with this cycle's inputs already set.
    task automatic step();
        logic        redir, pop, ereq, misal, apush;
        logic [31:0] tgt;
        logic [32:0] e;
        int          cnt, infl;
        inst_sram_data_ok = !reset && resp_en && (acc_q.size() != 0);
        inst_sram_rdata   = inst_sram_data_ok ? mem(acc_q[0]) : 32'h0;
        #1;
        delivered = 1'b0;
        if (reset) begin
            chk("rst_valid", 98'(fs_to_ds_valid), 98'(0));
            chk("rst_req", 98'(inst_sram_req), 98'(0));
            chk("rst_bus", fs_to_ds_bus, 98'(0));
            acc_q.delete();
            infl_q.delete();
            exp_q.delete();
            exp_fpc = RPC;
            halted  = 1'b0;
        end else begin
            redir = ws_ex | eret_flush | br_taken;
            tgt   = ws_ex ? EXE : (eret_flush ? cp0_epc : br_target);
            cnt   = exp_q.size();
            infl  = infl_q.size();
            chk("valid", 98'(fs_to_ds_valid), 98'(!redir && cnt != 0));
            pop   = !redir && (cnt != 0) && ds_allowin;
            misal = ADEL && (exp_fpc[1:0] != 2'b00);
            ereq  = !redir && !br_stall && !misal && (infl < MAXO) &&
                    (infl + cnt - int'(pop) < DEPTH);
            apush = misal && !halted && !redir && (infl == 0) && (cnt - int'(pop) < DEPTH);
            chk("req", 98'(inst_sram_req), 98'(ereq));
            if (ereq)
                chk("addr", 98'(inst_sram_addr), 98'(exp_fpc));
            if (pop) begin
                chk("bus", fs_to_ds_bus, exp_q[0]);
                last_bus  = fs_to_ds_bus;
                delivered = 1'b1;
                n_deliv++;
                void'(exp_q.pop_front());
            end
            if (inst_sram_data_ok) begin
                void'(acc_q.pop_front());
                if (infl_q.size() != 0) begin
                    e = infl_q.pop_front();
                    if (e[32] && !redir)
                        exp_q.push_back({1'b0, 1'b0, 32'h0, mem(e[31:0]), e[31:0]});
                end
            end
            if (apush) begin
                exp_q.push_back({1'b1, 1'b0, exp_fpc, 32'h0, exp_fpc});
                halted = 1'b1;
            end
            if (ereq && inst_sram_addr_ok) begin
                infl_q.push_back({1'b1, exp_fpc});
                exp_fpc = exp_fpc + 32'd4;
            end
            if (inst_sram_req && inst_sram_addr_ok) begin
                acc_q.push_back(inst_sram_addr);
                n_issue++;
            end
            if (redir) begin
                foreach (infl_q[i]) infl_q[i][32] = 1'b0;
                exp_q.delete();
                exp_fpc = tgt;
                halted  = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_deliver(input string tag);
        int k = 0;
        step();
        while (!delivered && k < 60) begin
            step();
            k++;
        end
        chk({tag, "_arrive"}, 98'(delivered), 98'(1));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int n0, d0;
        reset = 1'b1; ds_allowin = 1'b1; br_stall = 1'b0; br_taken = 1'b0;
        br_target = 32'h0; ws_ex = 1'b0; eret_flush = 1'b0; cp0_epc = 32'h0;
        inst_sram_addr_ok = 1'b1; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
        resp_en = 1'b1; delivered = 1'b0; last_bus = '0;
        exp_fpc = RPC; halted = 1'b0;
        @(negedge clk);
        steps(3);

        // Reset fetch: first word lands in cycle 2 after release, then one per cycle
        reset = 1'b0;
        step(); chk("lat_c0", 98'(delivered), 98'(0));
        step(); chk("lat_c1", 98'(delivered), 98'(0));
        step(); chk("lat_c2", 98'(delivered), 98'(1));
        chk("first_pc", 98'(last_bus[31:0]), 98'(RPC));
        d0 = n_deliv;
        steps(8);
        chk("throughput", 98'(n_deliv - d0), 98'(8));

        // Back-pressure from an empty pipe: exactly DEPTH requests go out
        inst_sram_addr_ok = 1'b0;
        steps(6);
        ds_allowin = 1'b0; inst_sram_addr_ok = 1'b1;
        n0 = n_issue;
        steps(10);
        chk("bp_issues", 98'(n_issue - n0), 98'(4));
        ds_allowin = 1'b1;
        steps(12);

        // Exception redirect with two requests in flight
        resp_en = 1'b0;
        steps(3);
        ws_ex = 1'b1; step(); ws_ex = 1'b0;
        resp_en = 1'b1;
        wait_deliver("ex");
        chk("ex_pc", 98'(last_bus[31:0]), 98'(EXE));
        steps(5);

        // eret in a cycle carrying a response
        cp0_epc = 32'h80002000;
        eret_flush = 1'b1; step(); eret_flush = 1'b0;
        wait_deliver("eret");
        chk("eret_pc", 98'(last_bus[31:0]), 98'(32'h80002000));
        steps(4);

        // Branch stall then taken branch
        br_stall = 1'b1;
        n0 = n_issue;
        steps(3);
        chk("stall_issues", 98'(n_issue - n0), 98'(0));
        br_stall = 1'b0; br_taken = 1'b1; br_target = 32'h80001000;
        step(); br_taken = 1'b0;
        wait_deliver("br");
        chk("br_pc", 98'(last_bus[31:0]), 98'(32'h80001000));
        steps(4);

        // Misaligned branch target
        br_taken = 1'b1; br_target = 32'h80000002;
        step(); br_taken = 1'b0;
        wait_deliver("mis");
        chk("mis_pc", 98'(last_bus[31:0]), 98'(32'h80000002));
        chk("mis_ex", 98'(last_bus[97]), 98'(ADEL));
        chk("mis_bad", 98'(last_bus[95:64]), 98'(ADEL ? 32'h80000002 : 32'h0));
        steps(6);
        br_taken = 1'b1; br_target = 32'h80003000;
        step(); br_taken = 1'b0;
        wait_deliver("realign");
        chk("realign_pc", 98'(last_bus[31:0]), 98'(32'h80003000));

        // Random traffic with occasional stalls and redirects
        for (int i = 0; i < 400; i++) begin
            int r;
            inst_sram_addr_ok = ($urandom_range(0, 3) != 0);
            resp_en           = ($urandom_range(0, 3) != 0);
            ds_allowin        = ($urandom_range(0, 2) != 0);
            br_stall          = ($urandom_range(0, 15) == 0);
            r = $urandom_range(0, 59);
            ws_ex      = (r == 0);
            eret_flush = (r == 1);
            br_taken   = (r == 2);
            br_target  = 32'h80000000 | (32'($urandom_range(0, 4095)) << 2);
            cp0_epc    = 32'h80010000 | (32'($urandom_range(0, 4095)) << 2);
            step();
        end
        ws_ex = 1'b0; eret_flush = 1'b0; br_taken = 1'b0; br_stall = 1'b0;
        inst_sram_addr_ok = 1'b1; resp_en = 1'b1; ds_allowin = 1'b1;
        steps(4);

        // Reset in the middle of traffic
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        wait_deliver("rerst");
        chk("rerst_pc", 98'(last_bus[31:0]), 98'(RPC));
        steps(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
